// File: rtl/axis_probe_switch_pkg.sv
// Shared types and constants for the host <-> probe AXI-Stream switch.
package axis_probe_switch_pkg;

  // Request side: wait for a routing header, forward its payload, or discard a misrouted packet.
  typedef enum logic [1:0] {
    REQ_HDR  = 2'd0,
    REQ_FWD  = 2'd1,
    REQ_DROP = 2'd2
  } req_state_t;

  // Response side: arbitrate between probes, then hold one probe until its packet ends.
  typedef enum logic [0:0] {
    RSP_IDLE = 1'b0,
    RSP_LOCK = 1'b1
  } rsp_state_t;

  // Width of the destination field in the header word. The routed index is the low DEST_W
  // bits of this field, but the whole field is range-checked. A header such as dest=5 on a
  // 4-probe build is therefore rejected rather than aliased onto probe 1.
  localparam int HDR_DEST_FIELD_W = 8;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first asserted request at or after ptr, wrapping.
module rr_arbiter
  import axis_probe_switch_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_any
);

  // Scan from the farthest offset back toward ptr, so the nearest hit overwrites the others.
  always_comb begin
    int idx;
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (req[IW'(idx)]) begin
        gnt_any = 1'b1;
        gnt_idx = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/axis_probe_switch.sv
// Shares one host AXI-Stream pair between PROBES_NUM probes. On the request side, the
// header word of each packet is stripped and the payload is routed to the addressed probe.
// On the response side, probe packets are merged by packet-atomic round-robin, and the
// source probe is tagged on m_axis_tid.
module axis_probe_switch
  import axis_probe_switch_pkg::*;
#(
  parameter int C_DATA_WIDTH = 128,
  parameter int PROBES_NUM   = 4,
  localparam int DEST_W      = $clog2(PROBES_NUM),
  localparam int KEEP_W      = C_DATA_WIDTH / 8
) (
  input  logic                           s_axis_aclk,
  input  logic                           s_axis_aresetn,
  // host request stream
  input  logic                           s_axis_tvalid,
  output logic                           s_axis_tready,
  input  logic                           s_axis_tlast,
  input  logic [C_DATA_WIDTH-1:0]        s_axis_tdata,
  input  logic [KEEP_W-1:0]              s_axis_tkeep,
  // per-probe request streams
  output logic [PROBES_NUM-1:0]          p_axis_tvalid,
  output logic [PROBES_NUM-1:0]          p_axis_tlast,
  input  logic [PROBES_NUM-1:0]          p_axis_tready,
  output logic [C_DATA_WIDTH*PROBES_NUM-1:0] p_axis_tdata,
  output logic [KEEP_W*PROBES_NUM-1:0]   p_axis_tkeep,
  // per-probe response streams
  input  logic [PROBES_NUM-1:0]          r_axis_tvalid,
  input  logic [PROBES_NUM-1:0]          r_axis_tlast,
  output logic [PROBES_NUM-1:0]          r_axis_tready,
  input  logic [C_DATA_WIDTH*PROBES_NUM-1:0] r_axis_tdata,
  input  logic [KEEP_W*PROBES_NUM-1:0]   r_axis_tkeep,
  // host response stream
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic                           m_axis_tlast,
  output logic [C_DATA_WIDTH-1:0]        m_axis_tdata,
  output logic [KEEP_W-1:0]              m_axis_tkeep,
  output logic [DEST_W-1:0]              m_axis_tid,
  // bad-header indication
  output logic                           hdr_err
);

  localparam logic [HDR_DEST_FIELD_W-1:0] DEST_LIMIT = HDR_DEST_FIELD_W'(PROBES_NUM);
  localparam logic [DEST_W-1:0]           LAST_IDX   = DEST_W'(PROBES_NUM - 1);

  // ---------------------------------------------------------------- request path
  req_state_t        req_state;
  logic [DEST_W-1:0] dest_ff;
  logic              s_hs;
  logic              hdr_bad;

  assign s_hs    = s_axis_tvalid && s_axis_tready;
  assign hdr_bad = (s_axis_tdata[HDR_DEST_FIELD_W-1:0] >= DEST_LIMIT);

  // Payload fans out to every probe. Only tvalid selects the destination.
  assign p_axis_tdata = {PROBES_NUM{s_axis_tdata}};
  assign p_axis_tkeep = {PROBES_NUM{s_axis_tkeep}};
  assign p_axis_tlast = {PROBES_NUM{s_axis_tlast}};

  // Zero-latency request handshake steering. While reset is asserted, the host sees no ready.
  always_comb begin
    s_axis_tready = 1'b0;
    p_axis_tvalid = '0;
    if (s_axis_aresetn) begin
      case (req_state)
        REQ_HDR:  s_axis_tready = 1'b1;
        REQ_FWD: begin
          p_axis_tvalid[dest_ff] = s_axis_tvalid;
          s_axis_tready          = p_axis_tready[dest_ff];
        end
        REQ_DROP: s_axis_tready = 1'b1;
        default:  s_axis_tready = 1'b0;
      endcase
    end
  end

  // Request FSM: consume the header, then forward or drop until the tlast handshake.
  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      req_state <= REQ_HDR;
      dest_ff   <= '0;
      hdr_err   <= 1'b0;
    end else begin
      hdr_err <= 1'b0;
      case (req_state)
        REQ_HDR: begin
          if (s_hs) begin
            dest_ff <= s_axis_tdata[DEST_W-1:0];
            if (s_axis_tlast) begin
              // Header with no payload: flag it and wait for the next header.
              hdr_err <= 1'b1;
            end else if (hdr_bad) begin
              hdr_err   <= 1'b1;
              req_state <= REQ_DROP;
            end else begin
              req_state <= REQ_FWD;
            end
          end
        end
        REQ_FWD, REQ_DROP: begin
          if (s_hs && s_axis_tlast) req_state <= REQ_HDR;
        end
        default: req_state <= REQ_HDR;
      endcase
    end
  end

  // ---------------------------------------------------------------- response path
  rsp_state_t        rsp_state;
  logic [DEST_W-1:0] grant_ff;
  logic [DEST_W-1:0] rr_ptr;
  logic [DEST_W-1:0] gnt_idx;
  logic              gnt_any;
  logic              m_hs;

  rr_arbiter #(
    .N (PROBES_NUM)
  ) u_arb (
    .req     (r_axis_tvalid),
    .ptr     (rr_ptr),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  assign m_hs       = m_axis_tvalid && m_axis_tready;
  assign m_axis_tid = grant_ff;

  // Mux the granted probe onto the host stream. Data is not qualified, but valid and last are.
  always_comb begin
    r_axis_tready = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tdata  = r_axis_tdata[int'(grant_ff)*C_DATA_WIDTH +: C_DATA_WIDTH];
    m_axis_tkeep  = r_axis_tkeep[int'(grant_ff)*KEEP_W +: KEEP_W];
    if (rsp_state == RSP_LOCK) begin
      m_axis_tvalid           = r_axis_tvalid[grant_ff];
      m_axis_tlast            = r_axis_tlast[grant_ff];
      r_axis_tready[grant_ff] = m_axis_tready;
    end
  end

  // Response FSM: grant on any request, hold the lock until tlast, then advance the pointer.
  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      rsp_state <= RSP_IDLE;
      grant_ff  <= '0;
      rr_ptr    <= '0;
    end else begin
      case (rsp_state)
        RSP_IDLE: begin
          if (gnt_any) begin
            grant_ff  <= gnt_idx;
            rsp_state <= RSP_LOCK;
          end
        end
        RSP_LOCK: begin
          if (m_hs && m_axis_tlast) begin
            rr_ptr    <= (grant_ff == LAST_IDX) ? '0 : grant_ff + 1'b1;
            rsp_state <= RSP_IDLE;
          end
        end
        default: rsp_state <= RSP_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_probe_switch.sv
// Directed bench for axis_probe_switch: table-driven request routing plus hand-written
// response arbitration and reset sequences.
module tb_axis_probe_switch;

  localparam int W  = 128;
  localparam int N  = 4;
  localparam int DW = 2;
  localparam int KW = W / 8;

  logic              clk = 1'b0;
  logic              aresetn;
  logic              s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [W-1:0]      s_axis_tdata;
  logic [KW-1:0]     s_axis_tkeep;
  logic [N-1:0]      p_axis_tvalid, p_axis_tlast;
  logic [N-1:0]      p_axis_tready = '1;
  logic [W*N-1:0]    p_axis_tdata;
  logic [KW*N-1:0]   p_axis_tkeep;
  logic [N-1:0]      r_axis_tvalid, r_axis_tlast, r_axis_tready;
  logic [W*N-1:0]    r_axis_tdata;
  logic [KW*N-1:0]   r_axis_tkeep;
  logic              m_axis_tvalid, m_axis_tlast;
  logic              m_axis_tready = 1'b1;
  logic [W-1:0]      m_axis_tdata;
  logic [KW-1:0]     m_axis_tkeep;
  logic [DW-1:0]     m_axis_tid;
  logic              hdr_err;

  always #5 clk = ~clk;

  axis_probe_switch #(.C_DATA_WIDTH(W), .PROBES_NUM(N)) dut (
    .s_axis_aclk(clk), .s_axis_aresetn(aresetn),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .p_axis_tvalid(p_axis_tvalid), .p_axis_tlast(p_axis_tlast), .p_axis_tready(p_axis_tready),
    .p_axis_tdata(p_axis_tdata), .p_axis_tkeep(p_axis_tkeep),
    .r_axis_tvalid(r_axis_tvalid), .r_axis_tlast(r_axis_tlast), .r_axis_tready(r_axis_tready),
    .r_axis_tdata(r_axis_tdata), .r_axis_tkeep(r_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tid(m_axis_tid),
    .hdr_err(hdr_err)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] req_data(input int v, input int w);
    return {32'hDA7A_0000, 32'(v), 32'd0, 32'(w)};
  endfunction
  function automatic logic [KW-1:0] req_keep(input int v, input int w);
    return 16'(v * 16 + w) ^ 16'hF0F0;
  endfunction
  function automatic logic [W-1:0] rsp_data(input int p, input int c);
    return {32'(p), 64'hBEEF_0000_CAFE_0000, 32'(c)};
  endfunction
  function automatic logic [KW-1:0] rsp_keep(input int p, input int c);
    return 16'(c * 7 + p);
  endfunction

  // ---------------- probe response sources
  int           src_cnt[N] = '{default: 0};
  int           src_end[N] = '{default: 0};
  logic [N-1:0] gap_en  = '0;
  logic [N-1:0] gap_now = '0;
  logic         m_rdy = 1'b1, m_rand = 1'b0, p_stall = 1'b0, p_hold = 1'b0;

  for (genvar g = 0; g < N; g++) begin : g_src
    assign r_axis_tvalid[g]            = (src_cnt[g] < src_end[g]) && !gap_now[g];
    assign r_axis_tlast[g]             = (src_cnt[g] == src_end[g] - 1);
    assign r_axis_tdata[g*W +: W]      = rsp_data(g, src_cnt[g]);
    assign r_axis_tkeep[g*KW +: KW]    = rsp_keep(g, src_cnt[g]);
  end

  // Source/sink ready driver: advances on observed handshakes, then re-randomizes stalls.
  initial begin : drv
    logic [N-1:0] hs_r, v_r;
    forever begin
      @(negedge clk);
      hs_r = r_axis_tvalid & r_axis_tready;
      v_r  = r_axis_tvalid;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (hs_r[i]) src_cnt[i] = src_cnt[i] + 1;
        if (!gap_en[i]) gap_now[i] = 1'b0;
        else if (hs_r[i] || !v_r[i]) gap_now[i] = ($urandom_range(0, 2) == 0);
      end
      m_axis_tready = m_rand ? ($urandom_range(0, 2) != 0) : m_rdy;
      p_axis_tready = p_hold ? '0 : (p_stall ? N'($urandom) : '1);
    end
  end

  // ---------------- monitor
  typedef struct packed {
    logic [DW-1:0] tid;
    logic [W-1:0]  data;
    logic [KW-1:0] keep;
    logic          last;
    int            cyc;
  } beat_t;

  beat_t m_log[512];
  beat_t p_log[512];
  int    m_n = 0, p_n = 0, err_n = 0, cyc = 0;

  initial begin : mon
    forever begin
      @(negedge clk);
      cyc++;
      if (m_axis_tvalid && m_axis_tready && m_n < 512) begin
        m_log[m_n] = '{m_axis_tid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, cyc};
        m_n++;
      end
      for (int i = 0; i < N; i++) begin
        if (p_axis_tvalid[i] && p_axis_tready[i] && p_n < 512) begin
          p_log[p_n] = '{DW'(i), p_axis_tdata[i*W +: W], p_axis_tkeep[i*KW +: KW],
                         p_axis_tlast[i], cyc};
          p_n++;
        end
      end
      if (hdr_err) err_n++;
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- helpers
  task automatic idle(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic send_pkt(input int v, input logic [7:0] dest, input int n, output int cycles);
    int   t;
    logic hs;
    cycles = 0;
    for (int w = 0; w <= n; w++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = (w == 0) ? {{15{8'hA5}}, dest} : req_data(v, w);
      s_axis_tkeep  = (w == 0) ? '1 : req_keep(v, w);
      s_axis_tlast  = (w == n);
      t  = 0;
      hs = 1'b0;
      do begin
        @(negedge clk);
        hs = s_axis_tready;
        @(posedge clk);
        #1;
        t++;
      end while (!hs && t < 200);
      cycles += t;
      if (!hs) begin
        tests++;
        fails++;
        $display("FAIL req_timeout: got no s_axis_tready after %0d cycles, required handshake", t);
        break;
      end
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic post(input int p, input int len, output int first);
    first      = src_end[p];
    src_end[p] = src_end[p] + len;
  endtask

  task automatic wait_beats(input int target, input int budget);
    int t = 0;
    while (m_n < target && t < budget) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (m_n < target) begin
      tests++;
      fails++;
      $display("FAIL rsp_timeout: got %0d beats required %0d", m_n, target);
    end
  endtask

  int rd = 0;
  int last_end_cyc = 0;

  task automatic check_pkt(input int p, input int first, input int len,
                           input bit contig, input bit gap);
    beat_t b;
    int    prev = 0;
    bit    ok = 1'b1;
    for (int k = 0; k < len; k++) begin
      b = m_log[rd];
      check("rsp_beat", 192'({b.tid, b.data, b.keep, b.last}),
            192'({DW'(p), rsp_data(p, first + k), rsp_keep(p, first + k), (k == len - 1)}));
      if (k == 0 && gap) check("rsp_gap", 192'(b.cyc - last_end_cyc), 192'(2));
      if (k > 0 && b.cyc != prev + 1) ok = 1'b0;
      prev = b.cyc;
      rd++;
    end
    if (contig) check("rsp_contig", 192'(ok), 192'(1));
    last_end_cyc = prev;
  endtask

  // ---------------- request vectors
  typedef struct {
    logic [7:0] dest;
    int         nwords;
    logic       stall;
    int         exp_err;
    int         exp_probe;   // -1: nothing reaches any probe
  } req_vec_t;

  req_vec_t rv[9];

  initial begin : main
    int c, p0, e0, ew, f0, f1, f2, f3;

    rv[0] = '{8'd2,   10, 1'b0, 0,  2};
    rv[1] = '{8'd5,    3, 1'b0, 1, -1};
    rv[2] = '{8'd1,    4, 1'b0, 0,  1};
    rv[3] = '{8'd0,    0, 1'b0, 1, -1};
    rv[4] = '{8'd3,    1, 1'b0, 0,  3};
    rv[5] = '{8'd0,    5, 1'b1, 0,  0};
    rv[6] = '{8'hFF,   2, 1'b0, 1, -1};
    rv[7] = '{8'd7,    0, 1'b0, 1, -1};
    rv[8] = '{8'd1,    2, 1'b0, 0,  1};

    aresetn       = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_state", 192'({s_axis_tready, p_axis_tvalid, r_axis_tready, m_axis_tvalid,
                               m_axis_tlast, m_axis_tid, hdr_err}), 192'(0));
    @(posedge clk);
    #3 aresetn = 1'b1;
    idle(1);

    // Request routing table
    for (int vi = 0; vi < 9; vi++) begin
      p_stall = rv[vi].stall;
      p0 = p_n;
      e0 = err_n;
      send_pkt(vi, rv[vi].dest, rv[vi].nwords, c);
      p_stall = 1'b0;
      idle(3);
      ew = (rv[vi].exp_probe < 0) ? 0 : rv[vi].nwords;
      check("hdr_err_pulses", 192'(err_n - e0), 192'(rv[vi].exp_err));
      check("probe_words", 192'(p_n - p0), 192'(ew));
      for (int k = 0; k < ew && k < p_n - p0; k++) begin
        check("route", 192'({p_log[p0+k].tid, p_log[p0+k].data, p_log[p0+k].keep, p_log[p0+k].last}),
              192'({DW'(rv[vi].exp_probe), req_data(vi, k + 1), req_keep(vi, k + 1),
                    (k == ew - 1)}));
      end
      if (!rv[vi].stall) check("req_cycles", 192'(c), 192'(rv[vi].nwords + 1));
    end

    // Probes 0, 1, 3 contend from rr_ptr=0
    rd = m_n;
    post(0, 10, f0);
    post(1, 10, f1);
    post(3, 10, f3);
    wait_beats(rd + 30, 300);
    check_pkt(0, f0, 10, 1, 0);
    check_pkt(1, f1, 10, 1, 1);
    check_pkt(3, f3, 10, 1, 1);
    idle(2);

    // After 3 the pointer wraps to 0: probe 1 must beat probe 3
    rd = m_n;
    post(1, 3, f1);
    post(3, 3, f3);
    wait_beats(rd + 6, 100);
    check_pkt(1, f1, 3, 1, 0);
    check_pkt(3, f3, 3, 1, 1);
    idle(2);

    // Locked probe 1 with valid gaps and host stalls; 2 and 3 arrive mid-packet
    rd = m_n;
    gap_en[1] = 1'b1;
    m_rand    = 1'b1;
    post(1, 12, f1);
    wait_beats(rd + 1, 200);
    post(2, 4, f2);
    post(3, 2, f3);
    wait_beats(rd + 18, 2000);
    check_pkt(1, f1, 12, 0, 0);
    check_pkt(2, f2, 4, 0, 0);
    check_pkt(3, f3, 2, 0, 0);
    gap_en = '0;
    m_rand = 1'b0;
    m_rdy  = 1'b1;
    idle(3);

    // Move rr_ptr to 2, then reset with both FSMs mid-packet
    rd = m_n;
    post(1, 2, f1);
    wait_beats(rd + 2, 100);
    check_pkt(1, f1, 2, 1, 0);
    idle(2);
    m_rdy  = 1'b0;
    p_hold = 1'b1;
    post(2, 5, f2);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = {{15{8'hA5}}, 8'd2};
    s_axis_tkeep  = '1;
    s_axis_tlast  = 1'b0;
    idle(1);
    s_axis_tdata = req_data(99, 1);
    s_axis_tkeep = req_keep(99, 1);
    idle(2);
    @(negedge clk);
    check("pre_reset_locked", 192'({p_axis_tvalid, m_axis_tvalid, m_axis_tid}),
          192'({4'b0100, 1'b1, 2'd2}));
    #2 aresetn = 1'b0;
    #1;
    check("reset_async", 192'({s_axis_tready, p_axis_tvalid, r_axis_tready, m_axis_tvalid,
                               m_axis_tlast, m_axis_tid, hdr_err}), 192'(0));
    s_axis_tvalid = 1'b0;
    src_end[2]    = src_cnt[2];
    p_hold        = 1'b0;
    m_rdy         = 1'b1;
    repeat (2) @(posedge clk);
    #3 aresetn = 1'b1;
    @(negedge clk);
    check("after_reset", 192'({s_axis_tready, m_axis_tvalid, p_axis_tvalid}),
          192'({1'b1, 1'b0, 4'b0000}));
    idle(1);

    // rr_ptr back at 0: probe 1 wins over probe 3
    rd = m_n;
    post(3, 3, f3);
    post(1, 3, f1);
    wait_beats(rd + 6, 100);
    check_pkt(1, f1, 3, 1, 0);
    check_pkt(3, f3, 3, 1, 1);

    // Request path usable again after reset
    p0 = p_n;
    send_pkt(50, 8'd1, 2, c);
    idle(2);
    check("post_reset_route", 192'({p_n - p0, p_log[p0].tid, p_log[p0].data}),
          192'({32'd2, 2'd1, req_data(50, 1)}));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axis_probe_switch.md
Name: axis_probe_switch

Overview:
- Shares one host AXI-Stream pair (XDMA H2C/C2H) between PROBES_NUM probe instances.
- Request side: the first word of every host packet is a routing header. It is stripped, and the rest of the packet goes to the addressed probe.
- Response side: probe response packets are merged onto one host stream by packet-atomic round-robin arbitration. The source index is tagged on m_axis_tid.

Parameters:
- C_DATA_WIDTH, 128, AXI-Stream data width in bits.
- PROBES_NUM, 4, number of attached probes (≥2).
- DEST_W, $clog2(PROBES_NUM) (localparam), probe index width.

Ports:
- s_axis_aclk  in  1  single clock for all logic.
- s_axis_aresetn  in  1  asynchronous active-low reset.
- s_axis_tvalid / s_axis_tready / s_axis_tlast  in/out/in  1  host request stream.
- s_axis_tdata  in  C_DATA_WIDTH  host request data; header word dest = tdata[DEST_W-1:0].
- s_axis_tkeep  in  C_DATA_WIDTH/8  forwarded unchanged.
- p_axis_tvalid / p_axis_tlast  out  PROBES_NUM  per-probe request valid/last.
- p_axis_tready  in  PROBES_NUM  per-probe request ready.
- p_axis_tdata  out  C_DATA_WIDTH*PROBES_NUM  flattened; slice i = [(i+1)*W-1 : i*W].
- p_axis_tkeep  out  C_DATA_WIDTH/8*PROBES_NUM  flattened as for tdata.
- r_axis_tvalid / r_axis_tlast  in  PROBES_NUM  per-probe response valid/last.
- r_axis_tready  out  PROBES_NUM  per-probe response ready.
- r_axis_tdata / r_axis_tkeep  in  flattened as for p_axis.
- m_axis_tvalid / m_axis_tready / m_axis_tlast  out/in/out  1  host response stream.
- m_axis_tdata / m_axis_tkeep  out  C_DATA_WIDTH, C_DATA_WIDTH/8.
- m_axis_tid  out  DEST_W  index of the granted probe.
- hdr_err  out  1  one-cycle pulse on a bad header.

Behaviour:
- Reset: s_axis_tready=0, p_axis_tvalid=0, r_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tid=0, hdr_err=0. Request FSM goes to REQ_HDR, response FSM to RSP_IDLE, rr pointer to 0. Reset mid-packet abandons the packet with no flush; the host and probes must be reset together.

Request FSM (states REQ_HDR, REQ_FWD, REQ_DROP):
- REQ_HDR: s_axis_tready=1, all p_axis_tvalid=0. On handshake, dest_ff is registered from tdata[DEST_W-1:0]. Transitions on that handshake:
  - tlast=1 (header-only packet) → hdr_err pulse next cycle; stay in REQ_HDR.
  - dest ≥ PROBES_NUM → hdr_err pulse; go to REQ_DROP.
  - otherwise → REQ_FWD.
- REQ_FWD: zero-latency combinational pass-through to the addressed probe.
  - p_axis_tvalid[dest_ff]=s_axis_tvalid; s_axis_tready=p_axis_tready[dest_ff]. Every other p_axis_tvalid=0.
  - tdata, tkeep and tlast are driven onto all slices; only tvalid is qualified.
  - Handshake with tlast=1 → REQ_HDR.
- REQ_DROP: s_axis_tready=1; words are discarded. Handshake with tlast=1 → REQ_HDR.
- Fixed header overhead: one handshake per packet, no throughput bubble after it.

Response FSM (states RSP_IDLE, RSP_LOCK):
- RSP_IDLE: all r_axis_tready=0, m_axis_tvalid=0. If any r_axis_tvalid is set, the winner is the first asserted index at or after rr_ptr (wrapping modulo PROBES_NUM). It is registered into grant_ff → RSP_LOCK.
- RSP_LOCK: pass-through from probe grant_ff.
  - m_axis_tvalid=r_axis_tvalid[grant_ff]; r_axis_tready[grant_ff]=m_axis_tready; tdata/tkeep/tlast come from slice grant_ff; m_axis_tid=grant_ff.
  - The grant is held until the tlast handshake. Then rr_ptr = (grant_ff+1) mod PROBES_NUM → RSP_IDLE.
- One idle cycle between granted packets is required.
- A tvalid that drops mid-packet keeps the lock.
- A probe whose tvalid rises while another holds the lock waits for the next arbitration.
- rr_ptr wraps PROBES_NUM-1 → 0. Non-power-of-2 PROBES_NUM is supported.
- The request and response FSMs are independent; simultaneous request and response traffic is legal.

Decomposition:
- Package axis_probe_switch_pkg: req_state_t {REQ_HDR, REQ_FWD, REQ_DROP} and rsp_state_t {RSP_IDLE, RSP_LOCK}.
- Sub-module rr_arbiter (parameter N): inputs req[N] and ptr; outputs gnt_idx and gnt_any; purely combinational. Ptr update and locking live in the parent.

Test Plan:
- Header dest=2, then 10 data words with tlast on word 10 → only p_axis_tvalid[2] toggles; 10 handshakes on probe 2; tlast on the 10th; header word never appears on p_axis_tdata.
- Header dest=5 (PROBES_NUM=4), then 3 words → hdr_err pulses once; all 3 words are accepted; no p_axis_tvalid is asserted; the next packet with dest=1 routes correctly.
- Header-only packet (tlast on the header) → hdr_err pulses; FSM stays in REQ_HDR; the next header is accepted.
- Probes 0, 1 and 3 present 10-word responses simultaneously with rr_ptr=0 → host sees packets in order tid=0, 1, 3, each contiguous, with one idle cycle between. After that rr_ptr=0, since 3+1 wraps.
- Probe 1 locked; random m_axis_tready stalls and probe 2 asserting tvalid mid-packet → no words from probe 2 interleave; probe 1 data is intact; probe 2 is granted next.
- Assert s_axis_aresetn low during REQ_FWD and RSP_LOCK → all valids/readies go to 0 immediately; after release, s_axis_tready=1 (REQ_HDR) and rr_ptr=0.
